text_lcd_buf_ctrl: RTL and testbench

- Parametrised HD44780-class character LCD controller with an 8-bit bus.
- Holds a ROWS x COLS character frame buffer that host logic writes at any time.
- Runs the power-up/init sequence itself, then streams the buffer to the panel, either continuously or only when the buffer has changed.
- Generates a proper LCD_E strobe; LCD_E is not tied to clk.
- Sits between board-level application FSMs and the LCD pins.

---
 rtl/text_lcd_buf_ctrl_pkg.sv | 40 ++++
 rtl/text_lcd_buf_ctrl_byte_writer.sv | 82 ++++++++
 rtl/text_lcd_buf_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_text_lcd_buf_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_lcd_buf_ctrl_pkg.sv
// Shared types and constants for the character LCD controller:
// FSM state encoding, HD44780 command bytes and the DDRAM line-base helper.
package lcd_pkg;

    typedef enum logic [3:0] {
        S_PWRUP,
        S_FSET,
        S_DISP,
        S_ENTRY,
        S_CLEAR,
        S_IDLE,
        S_ADDR,
        S_CHAR,
        S_WAIT
    } lcd_state_t;

    localparam logic [7:0] CMD_FSET   = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP   = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_ENTRY  = 8'h06;  // increment address, no shift
    localparam logic [7:0] CMD_CLEAR  = 8'h01;
    localparam logic [7:0] CMD_DDRAM  = 8'h80;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    // Width of every cycle counter and transaction length field.
    localparam int LEN_W = 16;

    // DDRAM start address of a display line. Lines 2 and 3 continue lines
    // 0 and 1 on 4-line panels, so their base depends on the line width.
    function automatic logic [6:0] line_base(input logic [1:0] row, input int cols);
        logic [6:0] c;
        c = 7'(cols);
        case (row)
            2'd0:    return 7'h00;
            2'd1:    return 7'h40;
            2'd2:    return c;
            default: return 7'h40 + c;
        endcase
    endfunction

endpackage

// File: rtl/text_lcd_buf_ctrl_byte_writer.sv
// One LCD bus transaction: RS/DATA are presented in cycle 0 with E low,
// E is high for E_HIGH cycles, then RS/DATA are held with E low until the
// transaction length has elapsed. done marks the last cycle so a new
// transaction can start back-to-back on the following edge.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int E_HIGH = 3
)(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             rs,
    input  logic [7:0]       data,
    input  logic [LEN_W-1:0] len,
    output logic             lcd_e,
    output logic             lcd_rs,
    output logic [7:0]       lcd_data,
    output logic             done
);

    logic             active_q, active_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_inc;
    logic             e_q, e_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;

    assign done     = active_q && (cnt_q == len_q - LEN_W'(1));
    assign lcd_e    = e_q;
    assign lcd_rs   = rs_q;
    assign lcd_data = data_q;

    // Transaction sequencing: latch the byte on start, then walk the cycle count.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        e_d      = e_q;
        rs_d     = rs_q;
        data_d   = data_q;
        cnt_inc  = cnt_q + LEN_W'(1);
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            len_d    = len;
            e_d      = 1'b0;
            rs_d     = rs;
            data_d   = data;
        end else if (active_q) begin
            if (done) begin
                active_d = 1'b0;
                cnt_d    = '0;
                e_d      = 1'b0;
            end else begin
                cnt_d = cnt_inc;
                e_d   = (cnt_inc <= LEN_W'(E_HIGH));
            end
        end
    end

    // Bus registers; resetn is active-high and clears the pins immediately.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            len_q    <= '0;
            e_q      <= 1'b0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            e_q      <= e_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: rtl/text_lcd_buf_ctrl.sv
// Character LCD controller: frame buffer written by the host at any time,
// an FSM that initialises the panel and then streams the buffer line by
// line, and the dirty tracking used when continuous refresh is disabled.
module text_lcd_buf_ctrl
    import lcd_pkg::*;
#(
    parameter int COLS         = 16,
    parameter int ROWS         = 2,
    parameter int WR_CYC       = 8,
    parameter int E_HIGH       = 3,
    parameter int PWRUP_CYC    = 70,
    parameter int CLEAR_CYC    = 200,
    parameter int REFRESH_CYC  = 400,
    parameter int AUTO_REFRESH = 1
)(
    input  logic       clk,
    input  logic       resetn,
    input  logic       wr_en,
    input  logic [1:0] wr_row,
    input  logic [4:0] wr_col,
    input  logic [7:0] wr_char,
    input  logic       clear_req,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA,
    output logic       init_done,
    output logic       busy
);

    localparam int         CELLS  = ROWS * COLS;
    localparam logic [2:0] ROWS_L = 3'(ROWS);
    localparam logic [4:0] COLS_L = 5'(COLS);

    lcd_state_t       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [1:0]       row_q, row_d;
    logic [4:0]       col_q, col_d;
    logic             init_done_q, init_done_d;
    logic             busy_q, busy_d;
    logic             dirty_q, dirty_d;
    logic             dirty_clr;
    logic [7:0]       cell_q [CELLS];
    logic [7:0]       cell_d [CELLS];

    logic             wr_hit;
    logic [6:0]       wr_idx;
    logic [6:0]       rd_idx;
    logic [7:0]       rd_char;
    logic             wr_start;
    logic             wr_rs;
    logic [7:0]       wr_data;
    logic [LEN_W-1:0] wr_len;
    logic             wr_done;

    // The panel is never read back.
    assign LCD_RW    = 1'b0;
    assign init_done = init_done_q;
    assign busy      = busy_q;

    assign wr_hit = wr_en && ({1'b0, wr_row} < ROWS_L) && (wr_col < COLS_L);
    assign wr_idx = 7'(wr_row) * 7'(COLS) + 7'(wr_col);
    assign rd_idx = 7'(row_d) * 7'(COLS) + 7'(col_d);

    // Next buffer contents: clear beats a simultaneous write.
    always_comb begin
        cell_d = cell_q;
        if (clear_req) begin
            for (int i = 0; i < CELLS; i++) cell_d[i] = CHAR_SPACE;
        end else if (wr_hit) begin
            for (int i = 0; i < CELLS; i++) begin
                if (wr_idx == 7'(i)) cell_d[i] = wr_char;
            end
        end
    end

    // Dirty flag: a set in the same cycle as the IDLE-exit clear wins.
    always_comb begin
        dirty_d = dirty_q;
        if (dirty_clr)            dirty_d = 1'b0;
        if (clear_req || wr_hit)  dirty_d = 1'b1;
    end

    // Character for the cell about to be sent, read at transaction start.
    always_comb begin
        rd_char = CHAR_SPACE;
        for (int i = 0; i < CELLS; i++) begin
            if (rd_idx == 7'(i)) rd_char = cell_q[i];
        end
    end

    // Frame buffer and dirty flag storage.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            for (int i = 0; i < CELLS; i++) cell_q[i] <= CHAR_SPACE;
            dirty_q <= 1'b1;
        end else begin
            cell_q  <= cell_d;
            dirty_q <= dirty_d;
        end
    end

    // FSM state register, position counters and registered status outputs.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q     <= S_PWRUP;
            cnt_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic: init sequence, then ADDR/CHAR per line, WAIT, IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        col_d     = col_q;
        dirty_clr = 1'b0;
        case (state_q)
            S_PWRUP: begin
                if (cnt_q == LEN_W'(PWRUP_CYC - 1)) state_d = S_FSET;
                else                                cnt_d   = cnt_q + LEN_W'(1);
            end
            S_FSET:  if (wr_done) state_d = S_DISP;
            S_DISP:  if (wr_done) state_d = S_ENTRY;
            S_ENTRY: if (wr_done) state_d = S_CLEAR;
            S_CLEAR: begin
                if (wr_done) begin
                    state_d = S_ADDR;
                    row_d   = 2'd0;
                end
            end
            S_ADDR:  if (wr_done) state_d = S_CHAR;
            S_CHAR: begin
                if (wr_done) begin
                    if (col_q == 5'(COLS - 1)) begin
                        if (row_q == 2'(ROWS - 1)) begin
                            state_d = S_WAIT;
                        end else begin
                            state_d = S_ADDR;
                            row_d   = row_q + 2'd1;
                        end
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == LEN_W'(REFRESH_CYC - 1)) state_d = S_IDLE;
                else                                  cnt_d   = cnt_q + LEN_W'(1);
            end
            S_IDLE: begin
                if ((AUTO_REFRESH != 0) || dirty_q) begin
                    state_d   = S_ADDR;
                    row_d     = 2'd0;
                    dirty_clr = 1'b1;
                end
            end
            default: state_d = S_PWRUP;
        endcase
        // Every state change restarts the cycle and column counters.
        if (state_d != state_q) begin
            cnt_d = '0;
            col_d = '0;
        end
    end

    // Output logic: launch the byte for the state being entered, or the next
    // character while staying in CHAR; compute registered status outputs.
    always_comb begin
        wr_start    = (state_d != state_q) || ((state_q == S_CHAR) && wr_done);
        wr_rs       = 1'b0;
        wr_data     = 8'h00;
        wr_len      = LEN_W'(WR_CYC);
        case (state_d)
            S_FSET:  wr_data = CMD_FSET;
            S_DISP:  wr_data = CMD_DISP;
            S_ENTRY: wr_data = CMD_ENTRY;
            S_CLEAR: begin
                wr_data = CMD_CLEAR;
                wr_len  = LEN_W'(CLEAR_CYC);
            end
            S_ADDR:  wr_data = CMD_DDRAM | {1'b0, line_base(row_d, COLS)};
            S_CHAR: begin
                wr_rs   = 1'b1;
                wr_data = rd_char;
            end
            default: wr_start = 1'b0;
        endcase
        init_done_d = init_done_q || ((state_q == S_CLEAR) && wr_done);
        busy_d      = (state_d != S_IDLE);
    end

    lcd_byte_writer #(
        .E_HIGH (E_HIGH)
    ) u_writer (
        .clk      (clk),
        .resetn   (resetn),
        .start    (wr_start),
        .rs       (wr_rs),
        .data     (wr_data),
        .len      (wr_len),
        .lcd_e    (LCD_E),
        .lcd_rs   (LCD_RS),
        .lcd_data (LCD_DATA),
        .done     (wr_done)
    );

endmodule

// File: tb/tb_text_lcd_buf_ctrl.sv
// Bench for text_lcd_buf_ctrl: two instances (default 2x16 continuous
// refresh, and 4x20 refresh-on-dirty). Stimulus pushes expected bus bytes
// into per-instance queues; a monitor pops and compares on each LCD_E rise
// and also checks E width and RS/DATA stability.
module tb_text_lcd_buf_ctrl;

    localparam int E_HIGH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: defaults
    logic       a_rst, a_wr_en, a_clear;
    logic [1:0] a_row;
    logic [4:0] a_col;
    logic [7:0] a_char;
    logic       a_e, a_rs, a_rw, a_init, a_busy;
    logic [7:0] a_data;

    // Instance B: 4x20, refresh on dirty only
    logic       b_rst, b_wr_en, b_clear;
    logic [1:0] b_row;
    logic [4:0] b_col;
    logic [7:0] b_char;
    logic       b_e, b_rs, b_rw, b_init, b_busy;
    logic [7:0] b_data;

    text_lcd_buf_ctrl #(
        .COLS(16), .ROWS(2), .WR_CYC(8), .E_HIGH(E_HIGH), .PWRUP_CYC(70),
        .CLEAR_CYC(200), .REFRESH_CYC(400), .AUTO_REFRESH(1)
    ) dut_a (
        .clk(clk), .resetn(a_rst), .wr_en(a_wr_en), .wr_row(a_row), .wr_col(a_col),
        .wr_char(a_char), .clear_req(a_clear), .LCD_E(a_e), .LCD_RS(a_rs),
        .LCD_RW(a_rw), .LCD_DATA(a_data), .init_done(a_init), .busy(a_busy)
    );

    text_lcd_buf_ctrl #(
        .COLS(20), .ROWS(4), .WR_CYC(8), .E_HIGH(E_HIGH), .PWRUP_CYC(70),
        .CLEAR_CYC(200), .REFRESH_CYC(400), .AUTO_REFRESH(0)
    ) dut_b (
        .clk(clk), .resetn(b_rst), .wr_en(b_wr_en), .wr_row(b_row), .wr_col(b_col),
        .wr_char(b_char), .clear_req(b_clear), .LCD_E(b_e), .LCD_RS(b_rs),
        .LCD_RW(b_rw), .LCD_DATA(b_data), .init_done(b_init), .busy(b_busy)
    );

    logic [8:0] exp_a[$];
    logic [8:0] exp_b[$];

    logic       e_prev  [2];
    logic       rs_prev [2];
    logic [7:0] d_prev  [2];
    int         hi_cnt  [2];
    int         tx_cnt  [2];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic push(input int k, input logic rs, input logic [7:0] d);
        if (k == 0) exp_a.push_back({rs, d});
        else        exp_b.push_back({rs, d});
    endtask

    task automatic push_init(input int k);
        push(k, 1'b0, 8'h38);
        push(k, 1'b0, 8'h0C);
        push(k, 1'b0, 8'h06);
        push(k, 1'b0, 8'h01);
    endtask

    // One full 4x20 pass on instance B, all spaces except optionally one cell.
    task automatic push_pass_b(input int srow, input int scol, input logic [7:0] sch);
        logic [7:0] base [4];
        base = '{8'h80, 8'hC0, 8'h94, 8'hD4};
        for (int r = 0; r < 4; r++) begin
            push(1, 1'b0, base[r]);
            for (int c = 0; c < 20; c++)
                push(1, 1'b1, (r == srow && c == scol) ? sch : 8'h20);
        end
    endtask

    // Per-instance bus monitor, evaluated on the falling clock edge.
    task automatic mon(input int k, input logic rst, input logic e,
                       input logic rs, input logic [7:0] d);
        logic [8:0] exp_v;
        logic       have;
        if (rst) begin
            e_prev[k] = 1'b0;
            hi_cnt[k] = 0;
        end else begin
            if (e && !e_prev[k]) begin
                tx_cnt[k]++;
                hi_cnt[k] = 1;
                chk($sformatf("setup_dut%0d", k), int'({rs, d}), int'({rs_prev[k], d_prev[k]}));
                have  = 1'b0;
                exp_v = '0;
                if (k == 0 && exp_a.size() > 0) begin exp_v = exp_a.pop_front(); have = 1'b1; end
                if (k == 1 && exp_b.size() > 0) begin exp_v = exp_b.pop_front(); have = 1'b1; end
                if (have) begin
                    $display("dut%0d tx %0d rs=%0b data=0x%02h expect rs=%0b data=0x%02h",
                             k, tx_cnt[k], rs, d, exp_v[8], exp_v[7:0]);
                    chk($sformatf("byte_dut%0d_tx%0d", k, tx_cnt[k]), int'({rs, d}), int'(exp_v));
                end
            end else if (e) begin
                hi_cnt[k]++;
                chk($sformatf("hold_dut%0d", k), int'({rs, d}), int'({rs_prev[k], d_prev[k]}));
            end else if (e_prev[k]) begin
                chk($sformatf("e_width_dut%0d", k), hi_cnt[k], E_HIGH);
            end
            e_prev[k]  = e;
            rs_prev[k] = rs;
            d_prev[k]  = d;
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_rst, a_e, a_rs, a_data);
        mon(1, b_rst, b_e, b_rs, b_data);
    end

    task automatic drain(input int k, input string name);
        int n;
        n = 0;
        while (((k == 0) ? exp_a.size() : exp_b.size()) > 0 && n < 8000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8000) fail_timeout(name);
    endtask

    // Wait until instance B has been idle (busy=0) for 30 consecutive cycles.
    task automatic wait_quiet_b(input string name);
        int run;
        int n;
        run = 0;
        n   = 0;
        while (run < 30 && n < 20000) begin
            @(negedge clk);
            n++;
            if (!b_busy) run++;
            else         run = 0;
        end
        if (run < 30) fail_timeout(name);
    endtask

    // Count cycles from reset release to the first E rise on instance B.
    task automatic first_e_b(input string name);
        int  n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            @(posedge clk);
            n++;
            #1;
            if (b_e) seen = 1'b1;
        end
        if (seen) chk(name, n, 71);
        else      fail_timeout(name);
    endtask

    task automatic write_b(input logic [1:0] r, input logic [4:0] c, input logic [7:0] ch);
        @(posedge clk); #1;
        b_wr_en = 1'b1; b_row = r; b_col = c; b_char = ch;
        @(posedge clk); #1;
        b_wr_en = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [7:0] hello [5];
        int   n;
        int   t0;
        logic seen;

        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        for (int k = 0; k < 2; k++) begin
            e_prev[k] = 1'b0; rs_prev[k] = 1'b0; d_prev[k] = 8'h00;
            hi_cnt[k] = 0;    tx_cnt[k]  = 0;
        end
        a_rst = 1'b1; a_wr_en = 1'b0; a_clear = 1'b0; a_row = '0; a_col = '0; a_char = '0;
        b_rst = 1'b1; b_wr_en = 1'b0; b_clear = 1'b0; b_row = '0; b_col = '0; b_char = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_e",      int'(a_e),    0);
        chk("rst_rs",     int'(a_rs),   0);
        chk("rst_rw",     int'(a_rw),   0);
        chk("rst_data",   int'(a_data), 0);
        chk("rst_init",   int'(a_init), 0);
        chk("rst_busy",   int'(a_busy), 1);
        chk("rst_rw_b",   int'(b_rw),   0);

        // ---- Instance A: init timing, HELLO written during power-up ----
        push_init(0);
        push(0, 1'b0, 8'h80);
        for (int i = 0; i < 5; i++)  push(0, 1'b1, hello[i]);
        for (int i = 0; i < 11; i++) push(0, 1'b1, 8'h20);
        push(0, 1'b0, 8'hC0);
        for (int i = 0; i < 16; i++) push(0, 1'b1, 8'h20);

        @(posedge clk); #1;
        a_rst = 1'b0;
        fork
            begin
                n    = 0;
                seen = 1'b0;
                while (!seen && n < 300) begin
                    @(posedge clk);
                    n++;
                    #1;
                    if (a_e) seen = 1'b1;
                end
                if (seen) chk("first_e_cycle", n, 71);
                else      fail_timeout("first_e_cycle");
                chk("first_e_data", int'(a_data), 8'h38);
                chk("first_e_rs",   int'(a_rs),   0);
            end
            begin
                @(posedge clk); #1;
                for (int i = 0; i < 5; i++) begin
                    a_wr_en = 1'b1; a_row = 2'd0; a_col = 5'(i); a_char = hello[i];
                    @(posedge clk); #1;
                end
                a_wr_en = 1'b0;
            end
        join

        n = 0;
        while (!(a_e && a_data == 8'h01) && n < 500) begin @(posedge clk); #1; n++; end
        if (n >= 500) fail_timeout("clear_tx");
        chk("init_done_during_clear", int'(a_init), 0);
        chk("busy_during_init",       int'(a_busy), 1);
        n = 0;
        while (!(a_e && !a_rs && a_data == 8'h80) && n < 500) begin @(posedge clk); #1; n++; end
        if (n >= 500) fail_timeout("first_addr_tx");
        chk("init_done_after_clear", int'(a_init), 1);
        drain(0, "drain_a_first_pass");
        chk("init_done_sticky", int'(a_init), 1);

        // ---- Instance B: 4x20 addresses, refresh on dirty only ----
        push_init(1);
        push_pass_b(-1, 0, 8'h20);
        @(posedge clk); #1;
        b_rst = 1'b0;
        drain(1, "drain_b_first_pass");
        wait_quiet_b("quiet_b_after_init");
        t0 = tx_cnt[1];
        repeat (2000) @(negedge clk);
        chk("idle_no_tx",   tx_cnt[1] - t0, 0);
        chk("idle_busy",    int'(b_busy),   0);

        // one write -> exactly one pass carrying the new character
        push_pass_b(1, 15, 8'h41);
        t0 = tx_cnt[1];
        write_b(2'd1, 5'd15, 8'h41);
        wait_quiet_b("quiet_b_after_write");
        chk("one_pass_tx_count", tx_cnt[1] - t0, 84);
        chk("write_pass_drained", exp_b.size(), 0);

        // out-of-range column is ignored and does not set dirty
        t0 = tx_cnt[1];
        write_b(2'd0, 5'd20, 8'h77);
        repeat (600) @(negedge clk);
        chk("bad_col_no_pass", tx_cnt[1] - t0, 0);
        chk("bad_col_busy",    int'(b_busy),   0);

        // clear together with a write: clear wins, pass is all spaces
        push_pass_b(-1, 0, 8'h20);
        t0 = tx_cnt[1];
        @(posedge clk); #1;
        b_clear = 1'b1; b_wr_en = 1'b1; b_row = 2'd0; b_col = 5'd0; b_char = 8'h5A;
        @(posedge clk); #1;
        b_clear = 1'b0; b_wr_en = 1'b0;
        wait_quiet_b("quiet_b_after_clear");
        chk("clear_pass_tx_count", tx_cnt[1] - t0, 84);
        chk("clear_pass_drained",  exp_b.size(), 0);

        // reset in the middle of the character stream
        write_b(2'd2, 5'd3, 8'h42);
        n = 0;
        while (!(b_e && b_rs) && n < 500) begin @(posedge clk); #1; n++; end
        if (n >= 500) fail_timeout("reach_char");
        @(posedge clk); #3;
        b_rst = 1'b1;
        #1;
        chk("midreset_e",    int'(b_e),    0);
        chk("midreset_data", int'(b_data), 0);
        chk("midreset_rs",   int'(b_rs),   0);
        chk("midreset_init", int'(b_init), 0);
        chk("midreset_busy", int'(b_busy), 1);
        exp_b.delete();
        push_init(1);
        push(1, 1'b0, 8'h80);
        push(1, 1'b1, 8'h20);
        @(posedge clk); #1;
        b_rst = 1'b0;
        first_e_b("restart_first_e_cycle");
        drain(1, "drain_b_restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
